// File: rtl/arbiter_puf_ctrl.sv
// Sequencer for an arbiter-PUF array: launches NUM_CH races per request, synchronises
// the raw arbiter outputs and, in vote mode, majority-votes NUM_EVAL evaluations per channel.
module arbiter_puf_ctrl #(
  parameter int CHAL_W     = 8,
  parameter int NUM_CH     = 8,
  parameter int NUM_EVAL   = 5,
  parameter int SETTLE_CYC = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [CHAL_W-1:0]        req_challenge,
  input  logic                     req_mode,
  output logic                     puf_pulse,
  output logic [NUM_CH*CHAL_W-1:0] puf_challenge,
  input  logic [NUM_CH-1:0]        puf_resp,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [NUM_CH-1:0]        rsp_data,
  output logic [NUM_CH-1:0]        rsp_unstable,
  output logic                     busy
);

  localparam int CW = $clog2(NUM_EVAL + 1);
  localparam int TW = $clog2(SETTLE_CYC + 2);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYC - 1);
  localparam logic [TW-1:0] FIRE_LAST   = TW'(SETTLE_CYC + 1);
  localparam logic [CW-1:0] EVAL_VOTE   = CW'(NUM_EVAL);

  typedef enum logic [2:0] {IDLE, ARM, FIRE, SAMPLE, DROP, VOTE, RESP} state_t;

  state_t                     state_q, state_d;
  logic [TW-1:0]              tmr_q, tmr_d;
  logic [CW-1:0]              eval_q, eval_d;
  logic                       mode_q, mode_d;
  logic [NUM_CH*CHAL_W-1:0]   chal_q, chal_d;
  logic [NUM_CH*CHAL_W-1:0]   chal_rot;
  logic [NUM_CH-1:0]          sync1_q, sync2_q;
  logic [NUM_CH-1:0]          vote_bit, unst_bit;
  logic [NUM_CH-1:0]          data_q, unst_q;
  logic                       pulse_q;
  logic [CW-1:0]              e_val;
  logic                       accept;
  logic                       clr_cnt;

  assign e_val   = mode_q ? EVAL_VOTE : CW'(1);
  assign accept  = (state_q == IDLE) && req_valid;
  assign clr_cnt = accept || (state_q == VOTE);

  // Channel k gets the base challenge rotated left by k: top half of the doubled word shifted.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_rot
    localparam int R = gi % CHAL_W;
    logic [2*CHAL_W-1:0] dbl;
    assign dbl = {req_challenge, req_challenge} << R;
    assign chal_rot[gi*CHAL_W +: CHAL_W] = dbl[2*CHAL_W-1 -: CHAL_W];
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_vote
    logic [CW-1:0] cnt_q;
    logic [CW:0]   twice;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                    cnt_q <= '0;
      else if (clr_cnt)           cnt_q <= '0;
      else if (state_q == SAMPLE) cnt_q <= cnt_q + CW'(sync2_q[gi]);
    end
    assign twice        = {cnt_q, 1'b0};
    assign vote_bit[gi] = twice > {1'b0, e_val};
    assign unst_bit[gi] = (cnt_q != '0) && (cnt_q != e_val);
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q + TW'(1);
    eval_d  = eval_q;
    mode_d  = mode_q;
    chal_d  = chal_q;
    case (state_q)
      IDLE: begin
        tmr_d = '0;
        if (req_valid) begin
          state_d = ARM;
          mode_d  = req_mode;
          chal_d  = chal_rot;
          eval_d  = '0;
        end
      end
      ARM: if (tmr_q == SETTLE_LAST) begin
        tmr_d   = '0;
        state_d = FIRE;
      end
      FIRE: if (tmr_q == FIRE_LAST) begin
        tmr_d   = '0;
        state_d = SAMPLE;
      end
      SAMPLE: begin
        tmr_d   = '0;
        eval_d  = eval_q + CW'(1);
        state_d = DROP;
      end
      DROP: if (tmr_q == SETTLE_LAST) begin
        tmr_d   = '0;
        state_d = (eval_q < e_val) ? FIRE : VOTE;
      end
      VOTE: begin
        tmr_d   = '0;
        eval_d  = '0;
        state_d = RESP;
      end
      RESP: begin
        tmr_d = '0;
        if (rsp_ready) state_d = IDLE;
      end
      default: begin
        tmr_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      eval_q  <= '0;
      mode_q  <= 1'b0;
      chal_q  <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      data_q  <= '0;
      unst_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      eval_q  <= eval_d;
      mode_q  <= mode_d;
      chal_q  <= chal_d;
      sync1_q <= puf_resp;
      sync2_q <= sync1_q;
      // Pulse is decoded from the next state so the flop lines up with FIRE/SAMPLE exactly.
      pulse_q <= (state_d == FIRE) || (state_d == SAMPLE);
      if (state_q == VOTE) begin
        data_q <= vote_bit;
        unst_q <= unst_bit;
      end
    end
  end

  assign req_ready     = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign rsp_valid     = (state_q == RESP);
  assign puf_pulse     = pulse_q;
  assign puf_challenge = chal_q;
  assign rsp_data      = data_q;
  assign rsp_unstable  = unst_q;

endmodule
